// File: rtl/button_pkg.sv
// Shared types for the pushbutton conditioning path.
//   btn_state_t : per-channel debounce FSM state
//   cnt_width() : width of the hold counter for a given debounce length
package button_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } btn_state_t;

  // The counter only has to reach cycles-1, so $clog2(cycles) bits are enough.
  // A single-cycle debounce still needs at least one bit to exist.
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM with hold counter,
// and registered edge pulses.
// Ports:
//   Clk     in  system clock, rising edge
//   Reset   in  synchronous active-high reset
//   Btn_In  in  raw asynchronous button level, active-high
//   Level   out debounced level (high in HIGH / FALL_WAIT)
//   Press   out 1-cycle pulse when a 0->1 change is accepted
//   Release out 1-cycle pulse when a 1->0 change is accepted
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn_In,
  output logic Level,
  output logic Press,
  output logic Release
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s;
  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_nxt;
  logic             release_nxt;
  logic             level_nxt;

  // State, counter, synchronizer and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1      <= 1'b0;
      s       <= 1'b0;
      state   <= LOW;
      cnt     <= '0;
      Level   <= 1'b0;
      Press   <= 1'b0;
      Release <= 1'b0;
    end else begin
      s1      <= Btn_In;
      s       <= s1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      Level   <= level_nxt;
      Press   <= press_nxt;
      Release <= release_nxt;
    end
  end

  // Next-state logic. The counter is cleared on entry to each wait state and
  // the exit compare fires at CNT_LAST, so it never wraps.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      LOW: begin
        if (s) begin
          state_nxt = RISE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_nxt = LOW;              // bounce: abandon quietly
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = FALL_WAIT;
          cnt_nxt   = '0;
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_nxt = HIGH;             // bounce: abandon quietly
        end else if (cnt == CNT_LAST) begin
          state_nxt   = LOW;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = LOW;
    endcase
    // Level registered from the next state so it rises with the Press pulse.
    level_nxt = (state_nxt == HIGH) || (state_nxt == FALL_WAIT);
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw pushbuttons into clean debounced levels and
// single-cycle press/release pulses. Channels are fully independent.
// Ports:
//   Clk          in  system clock, rising edge
//   Reset        in  synchronous active-high reset
//   Btn_In       in  [N_BTN] raw asynchronous button levels, active-high
//   Btn_Level    out [N_BTN] debounced levels
//   Btn_Press    out [N_BTN] 1-cycle pulse per accepted 0->1 change
//   Btn_Release  out [N_BTN] 1-cycle pulse per accepted 1->0 change
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Btn_In,
  output logic [N_BTN-1:0] Btn_Level,
  output logic [N_BTN-1:0] Btn_Press,
  output logic [N_BTN-1:0] Btn_Release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .Clk    (Clk),
      .Reset  (Reset),
      .Btn_In (Btn_In[i]),
      .Level  (Btn_Level[i]),
      .Press  (Btn_Press[i]),
      .Release(Btn_Release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (N_BTN=4, DEBOUNCE_CYCLES=4).
// Expected press/release pulses are queued with their due cycle when the
// stimulus is driven; every cycle the queue entries due now form the expected
// pulse vectors, so missing, late, early or extra pulses are all caught.
module tb_button_conditioner;
  localparam int N  = 4;
  localparam int DC = 4;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [N-1:0] Btn_In;
  logic [N-1:0] Btn_Level;
  logic [N-1:0] Btn_Press;
  logic [N-1:0] Btn_Release;

  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DC)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Btn_In     (Btn_In),
    .Btn_Level  (Btn_Level),
    .Btn_Press  (Btn_Press),
    .Btn_Release(Btn_Release)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int due;
    int ch;
    bit rel;
  } ev_t;

  ev_t sb[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;
  int  c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int ch, input bit rel, input int due);
    ev_t e;
    e.due = due; e.ch = ch; e.rel = rel;
    sb.push_back(e);
  endtask

  // Latency from driving at cycle c: sampled at edge c+1, pulse after edge c+1+DC+2.
  task automatic expect_mask(input logic [N-1:0] m, input bit rel);
    for (int i = 0; i < N; i++)
      if (m[i]) expect_pulse(i, rel, cyc + DC + 3);
  endtask

  // One clock: advance, then compare pulses against entries due this cycle.
  task automatic tick();
    logic [N-1:0] ep;
    logic [N-1:0] er;
    @(posedge Clk);
    cyc++;
    @(negedge Clk);
    ep = '0;
    er = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        if (sb[i].rel) er[sb[i].ch] = 1'b1;
        else           ep[sb[i].ch] = 1'b1;
        sb.delete(i);
      end
    end
    chk("press_sb", 32'(Btn_Press), 32'(ep));
    chk("release_sb", 32'(Btn_Release), 32'(er));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // 1: reset with all buttons held; held buttons are re-debounced after it.
    Reset  = 1'b1;
    Btn_In = 4'hF;
    tick();
    chk("rst_lvl_a", 32'(Btn_Level), 32'h0);
    tick();
    chk("rst_lvl_b", 32'(Btn_Level), 32'h0);
    Reset = 1'b0;
    expect_mask(4'hF, 1'b0);
    tick();
    chk("post_rst_lvl", 32'(Btn_Level), 32'h0);
    ticks(5);
    chk("held_rst_lvl_pre", 32'(Btn_Level), 32'h0);
    tick();
    chk("held_rst_lvl", 32'(Btn_Level), 32'hF);
    Btn_In = 4'h0;
    expect_mask(4'hF, 1'b1);
    ticks(6);
    chk("fall_wait_lvl", 32'(Btn_Level), 32'hF);
    tick();
    chk("released_lvl", 32'(Btn_Level), 32'h0);

    // 2: single press on channel 0, held 20 cycles, then released.
    Btn_In = 4'h1;
    expect_mask(4'h1, 1'b0);
    ticks(6);
    chk("t2_lvl_pre", 32'(Btn_Level), 32'h0);
    tick();
    chk("t2_lvl_up", 32'(Btn_Level), 32'h1);
    ticks(13);
    chk("t2_lvl_hold", 32'(Btn_Level), 32'h1);
    Btn_In = 4'h0;
    expect_mask(4'h1, 1'b1);
    ticks(6);
    chk("t2_lvl_fw", 32'(Btn_Level), 32'h1);
    tick();
    chk("t2_lvl_dn", 32'(Btn_Level), 32'h0);

    // 3: bouncy channel 1 never stays high long enough.
    Btn_In = 4'h2;
    ticks(3);
    Btn_In = 4'h0;
    tick();
    chk("t3_lvl_a", 32'(Btn_Level), 32'h0);
    Btn_In = 4'h2;
    ticks(3);
    chk("t3_lvl_b", 32'(Btn_Level), 32'h0);
    Btn_In = 4'h0;
    ticks(10);
    chk("t3_lvl_c", 32'(Btn_Level), 32'h0);

    // 4: simultaneous presses on channels 3:2.
    Btn_In = 4'hC;
    expect_mask(4'hC, 1'b0);
    ticks(7);
    chk("t4_press", 32'(Btn_Press), 32'hC);
    chk("t4_lvl", 32'(Btn_Level), 32'hC);
    Btn_In = 4'h0;
    expect_mask(4'hC, 1'b1);
    ticks(7);
    chk("t4_lvl_dn", 32'(Btn_Level), 32'h0);

    // 5: reset pulse while channel 0 sits in RISE_WAIT.
    Btn_In = 4'h1;
    ticks(3);
    Reset = 1'b1;
    tick();
    chk("t5_rst_lvl", 32'(Btn_Level), 32'h0);
    Reset = 1'b0;
    c = cyc;
    expect_pulse(0, 1'b0, c + 7);
    ticks(6);
    chk("t5_lvl_pre", 32'(Btn_Level), 32'h0);
    tick();
    chk("t5_lvl_up", 32'(Btn_Level), 32'h1);
    Btn_In = 4'h0;
    expect_mask(4'h1, 1'b1);
    ticks(7);
    chk("t5_lvl_dn", 32'(Btn_Level), 32'h0);

    // 6: long hold on channel 2, no auto-repeat.
    Btn_In = 4'h4;
    expect_mask(4'h4, 1'b0);
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (i == 6) chk("t6_lvl_pre", 32'(Btn_Level), 32'h0);
      if (i >= 7) chk("t6_lvl_hold", 32'(Btn_Level), 32'h4);
    end
    Btn_In = 4'h0;
    expect_mask(4'h4, 1'b1);
    ticks(7);
    chk("t6_lvl_dn", 32'(Btn_Level), 32'h0);

    ticks(3);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
